// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and state encoding for the serial adder
// Contents:
//   DEFAULT_WIDTH  default operand/result width
//   state_t        sequencer states IDLE/RUN/DONE
package adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_from_ha.sv
// rtl/fa_from_ha.sv - combinational 1-bit full adder from two half adders
// Ports:
//   a, b  in   operand bits
//   ci    in   carry in
//   s     out  sum bit
//   co    out  carry out (majority of a, b, ci)
module fa_from_ha (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (.a(a),  .b(b),  .s(s1), .c(c1));
  half_adder u_ha1 (.a(s1), .b(ci), .s(s),  .c(c2));

  // The two partial carries can never both be set, so OR equals majority.
  assign co = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - 1-bit half adder cell
// Ports:
//   a, b  in   operand bits
//   s     out  sum bit (a ^ b)
//   c     out  carry bit (a & b)
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder with start/busy/done handshake
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request, honoured in IDLE or DONE
//   a, b   in   WIDTH-bit operands, captured on the accepting edge
//   cin    in   carry in, captured on the accepting edge
//   busy   out  high while bits are being processed
//   done   out  one-cycle completion pulse
//   sum    out  registered result, updated only on completion
//   cout   out  registered final carry, updated only on completion
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // The accumulator's LSB would only ever be shifted out, so just the
  // upper WIDTH-1 bits are kept; the newest bit arrives via acc_next.
  logic [WIDTH-2:0] acc_hi;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             s;
  logic             co;
  logic [WIDTH-1:0] acc_next;

  fa_from_ha u_fa (
    .a (a_sh[0]),
    .b (b_sh[0]),
    .ci(c),
    .s (s),
    .co(co)
  );

  assign acc_next = {s, acc_hi};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      acc_hi <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            c      <= cin;
            cnt    <= '0;
            acc_hi <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          c      <= co;
          acc_hi <= acc_next[WIDTH-1:1];
          if (cnt == LAST) begin
            // Reset the counter here so it never reaches WIDTH.
            cnt   <= '0;
            sum   <= acc_next;
            cout  <= co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH 8 and 4)
`timescale 1ns/1ps
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;

  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  int         total = 0;
  int         bad   = 0;
  logic [8:0] prev8;
  logic [4:0] prev4;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the 8-bit DUT in IDLE or DONE; returns at the
  // negedge where done is seen (DUT in DONE), so a following call chains.
  task automatic run_op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input bit hold);
    logic [8:0] exp;
    int lat;
    int busyn;
    exp = {1'b0, av} + {1'b0, bv} + {8'b0, cv};
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    @(negedge clk);
    if (!hold) start8 = 1'b0;
    check({tag, " accept_busy"}, {31'b0, busy8}, 32'd1);
    lat = 0;
    busyn = 0;
    while (!done8 && lat < 40) begin
      if (busy8) busyn++;
      check({tag, " result_held"}, {23'b0, cout8, sum8}, {23'b0, prev8});
      if (hold) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    start8 = 1'b0;
    check({tag, " latency"}, lat, 32'd8);
    check({tag, " busy_cycles"}, busyn, 32'd8);
    check({tag, " busy_at_done"}, {31'b0, busy8}, 32'd0);
    check({tag, " sum"}, {24'b0, sum8}, {24'b0, exp[7:0]});
    check({tag, " cout"}, {31'b0, cout8}, {31'b0, exp[8]});
    prev8 = exp;
  endtask

  task automatic run_op4(input logic [3:0] av, input logic [3:0] bv, input logic cv);
    logic [4:0] exp;
    int lat;
    exp = {1'b0, av} + {1'b0, bv} + {4'b0, cv};
    a4 = av; b4 = bv; cin4 = cv; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 20) begin
      check("w4 result_held", {27'b0, cout4, sum4}, {27'b0, prev4});
      @(negedge clk);
      lat++;
    end
    check("w4 latency", lat, 32'd4);
    check("w4 sum_cout", {27'b0, cout4, sum4}, {27'b0, exp});
    prev4 = exp;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic seen;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    prev8 = '0;
    prev4 = '0;
    repeat (2) @(negedge clk);
    check("reset busy", {31'b0, busy8}, 32'd0);
    check("reset done", {31'b0, done8}, 32'd0);
    check("reset sum_cout", {23'b0, cout8, sum8}, 32'd0);
    check("reset w4 sum_cout", {27'b0, cout4, sum4}, 32'd0);
    rst_n = 1'b1;

    run_op8("basic", 8'h0F, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    check("basic done_pulse_end", {31'b0, done8}, 32'd0);
    check("basic idle_busy", {31'b0, busy8}, 32'd0);

    // Abort mid-RUN: reset asserted after edge 3.
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort busy", {31'b0, busy8}, 32'd0);
    check("abort done", {31'b0, done8}, 32'd0);
    check("abort sum_cout", {23'b0, cout8, sum8}, 32'd0);
    prev8 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | done8;
    end
    check("abort no_done", {31'b0, seen}, 32'd0);
    check("abort sum_after", {23'b0, cout8, sum8}, 32'd0);

    run_op8("wrap1", 8'hFF, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    run_op8("wrap2", 8'hFF, 8'hFF, 1'b1, 1'b0);
    @(negedge clk);

    run_op8("hold", 8'h3C, 8'h5A, 1'b1, 1'b1);
    @(negedge clk);
    check("hold single_done", {31'b0, done8}, 32'd0);
    check("hold no_restart", {31'b0, busy8}, 32'd0);

    run_op8("b2b_first", 8'h10, 8'h20, 1'b0, 1'b0);
    run_op8("b2b_second", 8'h02, 8'h03, 1'b0, 1'b0);
    check("b2b sum05", {24'b0, sum8}, 32'h05);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      run_op8("rand", 8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(3) == 0));
      if ($urandom_range(1) == 1) begin
        @(negedge clk);
        check("rand gap_done", {31'b0, done8}, 32'd0);
      end
    end

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      run_op4(v[3:0], v[7:4], v[8]);
    end
    @(negedge clk);
    check("w4 final_done", {31'b0, done4}, 32'd0);
    check("w4 final_busy", {31'b0, busy4}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
